jtopl_eg_step: RTL

- Per-operator envelope generator (ADSR) state machine.
- Consumes the global 15-bit envelope counter and its per-sample update strobe (zero && cen).
- Produces the operator's 9-bit attenuation, 0.1875 dB/LSB, 0 = loudest, 511 = silent.
- Sits directly downstream of the envelope counter; feeds the operator attenuation adder.

---
 rtl/jtopl_eg_step.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/jtopl_eg_step.sv
// Per-operator ADSR envelope generator producing a 9-bit attenuation (0 = loudest).
// Optional macro JTOPL_EG_STATE_EN adds the eg_state[1:0] output.
module jtopl_eg_step #(
    parameter logic [8:0] ATT_MAX = 9'd511
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic        zero,
    input  logic [14:0] eg_cnt,
    input  logic        keyon,
    input  logic [3:0]  ar,
    input  logic [3:0]  dr,
    input  logic [3:0]  rr,
    input  logic [3:0]  sl,
    input  logic        eg_type,
    input  logic        ksr,
    input  logic [3:0]  kc,
    output logic [8:0]  att,
    output logic        eg_off
`ifdef JTOPL_EG_STATE_EN
    ,
    output logic [1:0]  eg_state
`endif
);

    typedef enum logic [1:0] {
        ATTACK  = 2'd0,
        DECAY   = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t      state, next_state;
    logic [8:0]  next_att;
    logic        keyon_last;

    logic [3:0]  ofs;
    logic [3:0]  rate;
    logic [5:0]  eff_cur;
    logic [5:0]  eff_ar;
    logic [3:0]  inc;
    logic [9:0]  att_sum;
    logic [8:0]  att_up;
    logic [8:0]  att_dn;
    logic [12:0] prod;
    logic [9:0]  dec_amt;
    logic [8:0]  target;

    function automatic logic [5:0] eff_rate(input logic [3:0] r, input logic [3:0] o);
        logic [6:0] sum;
        sum = {1'b0, r, 2'b00} + {3'b000, o};
        if (r == 4'd0)
            return 6'd0;
        else if (sum > 7'd63)
            return 6'd63;
        else
            return sum[5:0];
    endfunction

    // Slow rates step only when the low counter bits are clear; fast rates step every update.
    function automatic logic [3:0] step_inc(input logic [5:0] eff, input logic [14:0] cnt);
        logic [7:0]  pat;
        logic [3:0]  hi;
        logic [3:0]  sh;
        logic [14:0] mask;
        logic [14:0] shifted;
        logic [3:0]  base;
        logic [3:0]  result;
        hi     = eff[5:2];
        result = 4'd0;
        case (eff[1:0])
            2'd0:    pat = 8'b10101010;
            2'd1:    pat = 8'b11101010;
            2'd2:    pat = 8'b11101110;
            default: pat = 8'b11111110;
        endcase
        if (hi >= 4'd13) begin
            base   = pat[cnt[2:0]] ? 4'd2 : 4'd1;
            result = base << (hi - 4'd13);
        end else if (hi != 4'd0) begin
            sh      = 4'd13 - hi;
            mask    = (15'd1 << sh) - 15'd1;
            shifted = cnt >> sh;
            if ((cnt & mask) == 15'd0)
                result = {3'b000, pat[shifted[2:0]]};
        end
        return result;
    endfunction

    always_comb begin
        ofs = ksr ? kc : {2'b00, kc[3:2]};
        case (state)
            ATTACK:  rate = ar;
            DECAY:   rate = dr;
            SUSTAIN: rate = eg_type ? 4'd0 : rr;
            default: rate = rr;
        endcase
        eff_cur = eff_rate(rate, ofs);
        eff_ar  = eff_rate(ar, ofs);
        inc     = step_inc(eff_cur, eg_cnt);

        att_sum = {1'b0, att} + {6'd0, inc};
        att_up  = (att_sum > {1'b0, ATT_MAX}) ? ATT_MAX : att_sum[8:0];

        prod    = {4'd0, att} * {9'd0, inc};
        dec_amt = {1'b0, prod[12:3]} + 10'd1;
        att_dn  = ({1'b0, att} > dec_amt) ? (att - dec_amt[8:0]) : 9'd0;

        target  = (sl == 4'd15) ? 9'd496 : {1'b0, sl, 4'b0000};
    end

    // Key edges take priority over the rate update in the same cen cycle.
    always_comb begin
        next_state = state;
        next_att   = att;
        if (cen) begin
            if (keyon && !keyon_last) begin
                if (eff_ar >= 6'd60) begin
                    next_att   = 9'd0;
                    next_state = DECAY;
                end else begin
                    next_state = ATTACK;
                end
            end else if (!keyon && keyon_last) begin
                next_state = RELEASE;
            end else if (zero) begin
                case (state)
                    ATTACK: begin
                        if (inc != 4'd0) begin
                            next_att = att_dn;
                            if (att_dn == 9'd0)
                                next_state = DECAY;
                        end
                    end
                    DECAY: begin
                        next_att = att_up;
                        if (att_up >= target)
                            next_state = SUSTAIN;
                    end
                    default: next_att = att_up;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RELEASE;
            att        <= ATT_MAX;
            keyon_last <= 1'b0;
            eg_off     <= 1'b1;
        end else begin
            state  <= next_state;
            att    <= next_att;
            eg_off <= (state == RELEASE) && (att == ATT_MAX);
            if (cen)
                keyon_last <= keyon;
        end
    end

`ifdef JTOPL_EG_STATE_EN
    assign eg_state = state;
`endif

endmodule
